// File: rtl/pong_pkg.sv
// Shared types and the paddle occupancy rule for the pong ball engine.
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      MISS = 2'd2,
      OVER = 2'd3
   } state_t;

   localparam logic DIR_POS = 1'b0;
   localparam logic DIR_NEG = 1'b1;

   localparam int MAX_WIDTH = 32;

   // Paddle start is clamped so a paddle parked at the right edge stays fully on screen.
   function automatic logic [MAX_WIDTH-1:0] paddle_mask(input int pos, input int width,
                                                        input int size);
      int p_eff;
      logic [MAX_WIDTH-1:0] m;
      p_eff = (pos > width - size) ? width - size : pos;
      m = '0;
      for (int c = 0; c < MAX_WIDTH; c++) begin
         if (c < width && c >= p_eff && c < p_eff + size) m[c] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/pong_ball_engine_mask.sv
// Combinational paddle position to lit-column mask.
module pong_paddle_mask
   import pong_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int BIT_OF_WIDTH = 3,
   parameter int SIZE         = 2
) (
   input  logic [BIT_OF_WIDTH-1:0] pos,
   output logic [WIDTH-1:0]        mask
);

   always_comb begin
      mask = WIDTH'(paddle_mask(int'(pos), WIDTH, SIZE));
   end

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball engine: ball motion, paddle/wall collision, scoring and LED matrix render.
//
// state | meaning
// IDLE  | ball parked at centre, waiting for serve
// PLAY  | ball stepping once per TICK_DIV ticks
// MISS  | ball shown in the paddle row for one step after a point
// OVER  | a player reached MAX_SCORE; frozen until reset
module pong_ball_engine
   import pong_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int HEIGHT        = 8,
   parameter int BIT_OF_WIDTH  = 3,
   parameter int BIT_OF_HEIGHT = 3,
   parameter int SIZE          = 2,
   parameter int TICK_DIV      = 4,
   parameter int SCORE_BITS    = 4,
   parameter int MAX_SCORE     = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick,
   input  logic                     serve,
   input  logic [BIT_OF_WIDTH-1:0]  player_top,
   input  logic [BIT_OF_WIDTH-1:0]  player_down,
   input  logic [BIT_OF_HEIGHT-1:0] count,
   output logic [WIDTH-1:0]         matrix_out,
   output logic [BIT_OF_WIDTH-1:0]  ball_x,
   output logic [BIT_OF_HEIGHT-1:0] ball_y,
   output logic                     hit_top,
   output logic                     hit_down,
   output logic [SCORE_BITS-1:0]    score_top,
   output logic [SCORE_BITS-1:0]    score_down,
   output logic                     game_over
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   localparam logic [BIT_OF_WIDTH-1:0] X_MAX = BIT_OF_WIDTH'(WIDTH - 1);
   localparam logic [BIT_OF_WIDTH-1:0] X_CTR = BIT_OF_WIDTH'(WIDTH / 2);
   localparam logic [BIT_OF_WIDTH-1:0] X_ONE = BIT_OF_WIDTH'(1);

   localparam logic [BIT_OF_HEIGHT-1:0] Y_CTR         = BIT_OF_HEIGHT'(HEIGHT / 2);
   localparam logic [BIT_OF_HEIGHT-1:0] Y_ONE         = BIT_OF_HEIGHT'(1);
   localparam logic [BIT_OF_HEIGHT-1:0] Y_TWO         = BIT_OF_HEIGHT'(2);
   localparam logic [BIT_OF_HEIGHT-1:0] Y_NEAR_DOWN   = BIT_OF_HEIGHT'(HEIGHT - 2);
   localparam logic [BIT_OF_HEIGHT-1:0] Y_BOUNCE_DOWN = BIT_OF_HEIGHT'(HEIGHT - 3);
   localparam logic [BIT_OF_HEIGHT-1:0] Y_LAST        = BIT_OF_HEIGHT'(HEIGHT - 1);

   localparam logic [SCORE_BITS-1:0] SCORE_END = SCORE_BITS'(MAX_SCORE);
   localparam logic [SCORE_BITS-1:0] SCORE_ONE = SCORE_BITS'(1);

   state_t state_q, state_d;
   logic [PW-1:0] presc_q;
   logic dx_q, dy_q;
   logic counting, moving, step;
   logic [WIDTH-1:0] top_mask, down_mask, render_d;
   logic [BIT_OF_WIDTH-1:0] nx;
   logic [BIT_OF_HEIGHT-1:0] ny;
   logic ndx, ndy, hit_top_d, hit_down_d, lose_top, lose_down;

   pong_paddle_mask #(.WIDTH(WIDTH), .BIT_OF_WIDTH(BIT_OF_WIDTH), .SIZE(SIZE)) u_mask_top (
      .pos  (player_top),
      .mask (top_mask)
   );

   pong_paddle_mask #(.WIDTH(WIDTH), .BIT_OF_WIDTH(BIT_OF_WIDTH), .SIZE(SIZE)) u_mask_down (
      .pos  (player_down),
      .mask (down_mask)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (serve) state_d = PLAY;
         PLAY:    if (step && (lose_top || lose_down)) state_d = MISS;
         MISS: begin
            if (step) begin
               state_d = (score_top >= SCORE_END || score_down >= SCORE_END) ? OVER : IDLE;
            end
         end
         OVER:    state_d = OVER;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      counting  = (state_q == PLAY) || (state_q == MISS);
      moving    = (state_q == PLAY);
      game_over = (state_q == OVER);
   end

   // Horizontal move resolves first; the paddle test uses the post-reflection column.
   always_comb begin
      step = counting && tick && (presc_q == PRE_LAST);

      ndx = dx_q;
      if (dx_q == DIR_POS) begin
         if (ball_x == X_MAX) begin
            nx  = ball_x - X_ONE;
            ndx = DIR_NEG;
         end else begin
            nx = ball_x + X_ONE;
         end
      end else begin
         if (ball_x == '0) begin
            nx  = X_ONE;
            ndx = DIR_POS;
         end else begin
            nx = ball_x - X_ONE;
         end
      end

      ny         = ball_y;
      ndy        = dy_q;
      hit_top_d  = 1'b0;
      hit_down_d = 1'b0;
      lose_top   = 1'b0;
      lose_down  = 1'b0;
      if (dy_q == DIR_NEG && ball_y == Y_ONE) begin
         if (top_mask[nx]) begin
            ny        = Y_TWO;
            ndy       = DIR_POS;
            hit_top_d = 1'b1;
         end else begin
            ny       = '0;
            lose_top = 1'b1;
         end
      end else if (dy_q == DIR_POS && ball_y == Y_NEAR_DOWN) begin
         if (down_mask[nx]) begin
            ny         = Y_BOUNCE_DOWN;
            ndy        = DIR_NEG;
            hit_down_d = 1'b1;
         end else begin
            ny        = Y_LAST;
            lose_down = 1'b1;
         end
      end else if (dy_q == DIR_POS) begin
         ny = ball_y + Y_ONE;
      end else begin
         ny = ball_y - Y_ONE;
      end
   end

   always_comb begin
      render_d = '0;
      if (count == '0)     render_d = render_d | top_mask;
      if (count == Y_LAST) render_d = render_d | down_mask;
      if (count == ball_y) render_d = render_d | (WIDTH'(1) << ball_x);
   end

   // dy is left alone on a miss: it already points at the player who lost the point.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q    <= '0;
         ball_x     <= X_CTR;
         ball_y     <= Y_CTR;
         dx_q       <= DIR_POS;
         dy_q       <= DIR_POS;
         score_top  <= '0;
         score_down <= '0;
         hit_top    <= 1'b0;
         hit_down   <= 1'b0;
         matrix_out <= '0;
      end else begin
         hit_top    <= 1'b0;
         hit_down   <= 1'b0;
         matrix_out <= render_d;
         if (state_q == IDLE && serve) begin
            presc_q <= '0;
         end else if (counting && tick) begin
            presc_q <= (presc_q == PRE_LAST) ? '0 : presc_q + PRE_ONE;
         end
         if (step && moving) begin
            ball_x   <= nx;
            ball_y   <= ny;
            dx_q     <= ndx;
            dy_q     <= ndy;
            hit_top  <= hit_top_d;
            hit_down <= hit_down_d;
            if (lose_top && score_down != '1)  score_down <= score_down + SCORE_ONE;
            if (lose_down && score_top != '1)  score_top  <= score_top + SCORE_ONE;
         end else if (step && state_d == IDLE) begin
            ball_x <= X_CTR;
            ball_y <= Y_CTR;
         end
      end
   end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine with an integer game model checked every cycle.
module tb_pong_ball_engine;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int SZ   = 2;
   localparam int TD   = 4;
   localparam int MAXS = 9;
   localparam int SMAX = 15;

   localparam int PH_IDLE = 0;
   localparam int PH_PLAY = 1;
   localparam int PH_MISS = 2;
   localparam int PH_OVER = 3;

   logic       clk = 1'b0;
   logic       rst_n, tick, serve;
   logic [2:0] player_top, player_down, count;
   logic [7:0] matrix_out;
   logic [2:0] ball_x, ball_y;
   logic       hit_top, hit_down, game_over;
   logic [3:0] score_top, score_down;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   int m_x, m_y, m_dx, m_dy, m_pre, m_st, m_sd, m_ph, m_ht, m_hd;
   logic [7:0] m_mat;

   pong_ball_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .serve       (serve),
      .player_top  (player_top),
      .player_down (player_down),
      .count       (count),
      .matrix_out  (matrix_out),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .hit_top     (hit_top),
      .hit_down    (hit_down),
      .score_top   (score_top),
      .score_down  (score_down),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit covers(input int p, input int c);
      int pe;
      pe = (p > W - SZ) ? W - SZ : p;
      return (c >= pe && c < pe + SZ);
   endfunction

   // Game model: plain integer positions and signed directions.
   always @(posedge clk) begin : model
      int nx;
      logic [7:0] mat;
      mat = '0;
      for (int c = 0; c < W; c++) begin
         if (int'(count) == 0 && covers(int'(player_top), c)) mat[c] = 1'b1;
         if (int'(count) == H - 1 && covers(int'(player_down), c)) mat[c] = 1'b1;
         if (int'(count) == m_y && c == m_x) mat[c] = 1'b1;
      end
      if (!rst_n) begin
         m_x = W / 2; m_y = H / 2; m_dx = 1; m_dy = 1; m_pre = 0;
         m_st = 0; m_sd = 0; m_ph = PH_IDLE; m_ht = 0; m_hd = 0; m_mat = '0;
      end else begin
         m_mat = mat;
         m_ht  = 0;
         m_hd  = 0;
         if (m_ph == PH_IDLE) begin
            if (serve) begin
               m_ph  = PH_PLAY;
               m_pre = 0;
            end
         end else if ((m_ph == PH_PLAY || m_ph == PH_MISS) && tick) begin
            if (m_pre < TD - 1) begin
               m_pre++;
            end else begin
               m_pre = 0;
               if (m_ph == PH_MISS) begin
                  if (m_st >= MAXS || m_sd >= MAXS) m_ph = PH_OVER;
                  else begin
                     m_ph = PH_IDLE; m_x = W / 2; m_y = H / 2;
                  end
               end else begin
                  nx = m_x + m_dx;
                  if (nx < 0 || nx > W - 1) begin
                     m_dx = -m_dx;
                     nx   = m_x + m_dx;
                  end
                  if (m_dy < 0 && m_y == 1) begin
                     if (covers(int'(player_top), nx)) begin
                        m_dy = 1; m_y = 2; m_ht = 1;
                     end else begin
                        m_y = 0; m_ph = PH_MISS;
                        if (m_sd < SMAX) m_sd++;
                     end
                  end else if (m_dy > 0 && m_y == H - 2) begin
                     if (covers(int'(player_down), nx)) begin
                        m_dy = -1; m_y = H - 3; m_hd = 1;
                     end else begin
                        m_y = H - 1; m_ph = PH_MISS;
                        if (m_st < SMAX) m_st++;
                     end
                  end else begin
                     m_y = m_y + m_dy;
                  end
                  m_x = nx;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ball_x",     32'(ball_x),     m_x);
         chk("ball_y",     32'(ball_y),     m_y);
         chk("hit_top",    32'(hit_top),    m_ht);
         chk("hit_down",   32'(hit_down),   m_hd);
         chk("score_top",  32'(score_top),  m_st);
         chk("score_down", 32'(score_down), m_sd);
         chk("game_over",  32'(game_over),  32'(m_ph == PH_OVER));
         chk("matrix_out", 32'(matrix_out), 32'(m_mat));
      end
   end

   task automatic pulse_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) begin
         pulse_tick();
         @(negedge clk);
      end
   endtask

   task automatic chk_ball(input string nm, input int x, input int y);
      chk({nm, "_x"}, 32'(ball_x), x);
      chk({nm, "_y"}, 32'(ball_y), y);
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; serve = 1'b0;
      player_top = 3'd3; player_down = 3'd0; count = 3'd0;
      @(negedge clk);
      chk_on = 1'b1;
      chk_ball("reset_ball", 4, 4);
      chk("reset_matrix", 32'(matrix_out), 0);
      chk("reset_game_over", 32'(game_over), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("render_top_p3", 32'(matrix_out), 32'(8'b0001_1000));
      count = 3'd4;
      @(negedge clk);
      chk("render_ball_row4", 32'(matrix_out), 32'(8'b0001_0000));

      serve = 1'b1; tick = 1'b1;
      @(negedge clk);
      serve = 1'b0; tick = 1'b0;
      @(negedge clk);
      step_n(3);
      chk_ball("three_ticks", 4, 4);
      step_n(1);
      chk_ball("first_step", 5, 5);
      step_n(4);
      chk_ball("second_step", 6, 6);

      step_n(3);
      player_down = 3'd6;
      pulse_tick();
      player_down = 3'd0;
      chk("hit_down_pulse", 32'(hit_down), 1);
      chk_ball("down_return", 7, 5);
      player_top = 3'd7; count = 3'd0;
      @(negedge clk);
      chk("hit_down_one_cycle", 32'(hit_down), 0);
      chk("render_top_clamped", 32'(matrix_out), 32'(8'b1100_0000));

      step_n(4);
      chk_ball("right_wall", 6, 4);
      step_n(16);
      chk_ball("top_miss", 2, 0);
      chk("score_down_1", 32'(score_down), 1);
      step_n(4);
      chk_ball("recentre", 4, 4);

      player_top = 3'd0;
      serve = 1'b1;
      @(negedge clk);
      serve = 1'b0;
      step_n(4);
      chk_ball("serve_toward_top", 3, 3);
      step_n(8);
      step_n(3);
      pulse_tick();
      chk("hit_top_pulse", 32'(hit_top), 1);
      chk_ball("top_return", 0, 2);
      @(negedge clk);
      step_n(4);
      chk_ball("left_wall", 1, 3);
      step_n(16);
      chk_ball("down_miss", 5, 7);
      chk("score_top_1", 32'(score_top), 1);
      step_n(4);
      serve = 1'b1;
      @(negedge clk);
      serve = 1'b0;
      step_n(4);
      chk_ball("serve_toward_down", 5, 5);

      // Keep paddles away from the ball so every rally ends in a point.
      serve = 1'b1;
      for (int i = 0; i < 20000 && m_ph != PH_OVER; i++) begin
         player_top  = (m_x >= 4) ? 3'd0 : 3'd6;
         player_down = (m_x >= 4) ? 3'd0 : 3'd6;
         tick  = (i % 2 == 0);
         count = 3'(count + 3'd1);
         @(negedge clk);
      end
      for (int i = 0; i < 16; i++) begin
         tick  = (i % 2 == 0);
         count = 3'(count + 3'd1);
         @(negedge clk);
      end
      tick = 1'b0; serve = 1'b0;
      chk("game_over_set", 32'(game_over), 1);
      chk("winning_score", (score_top > score_down) ? 32'(score_top) : 32'(score_down), 9);

      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_game_over", 32'(game_over), 0);
      chk("rst_score_top", 32'(score_top), 0);
      chk("rst_score_down", 32'(score_down), 0);
      chk("rst_matrix", 32'(matrix_out), 0);
      chk_ball("rst_ball", 4, 4);
      rst_n = 1'b1;
      @(negedge clk);
      chk_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
